mixer_seq: RTL

//  Bus initiator for the mixer control register interface: sequences the PD, OTA
//  and BUFF register writes for mixer power-up/power-down with programmable settle

---
 rtl/mixer_seq_pkg.sv | 20 ++
 rtl/mixer_seq_step_rom.sv | 26 ++
 rtl/mixer_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mixer_seq_pkg.sv
// mixer_seq_pkg: shared widths, mixer register map and sequencer state encodings
package mixer_seq_pkg;
   localparam int MIXER_ADDR_W = 4;
   localparam int DATA_W       = 8;
   localparam logic [MIXER_ADDR_W-1:0] MIXER_PD   = 4'd0;
   localparam logic [MIXER_ADDR_W-1:0] MIXER_OTA  = 4'd1;
   localparam logic [MIXER_ADDR_W-1:0] MIXER_BUFF = 4'd2;
   localparam logic [1:0] LAST_STEP = 2'd2;
   typedef enum logic [2:0] {
      MSEQ_IDLE,
      MSEQ_WR,
      MSEQ_REL,
      MSEQ_SETTLE,
      MSEQ_FIN
   } mseq_state_e;
   typedef enum logic {
      DIR_UP,
      DIR_DOWN
   } mseq_dir_e;
endpackage

// File: rtl/mixer_seq_step_rom.sv
// mixer_seq_step_rom: maps (direction, step) to register address, value and settle time
module mixer_seq_step_rom
   import mixer_seq_pkg::*;
#(
   parameter int T_PD   = 100,
   parameter int T_OTA  = 50,
   parameter int T_BUFF = 10,
   parameter int CNT_W  = 16
) (
   input  mseq_dir_e               dir_i,
   input  logic [1:0]              step_i,
   input  logic [1:0]              buff_i,
   output logic [MIXER_ADDR_W-1:0] addr_o,
   output logic [1:0]              val_o,
   output logic [CNT_W-1:0]        settle_o
);
   logic [1:0] reg_sel;
   // power-down walks the same register list backwards; reg_sel 0/1/2 = PD/OTA/BUFF
   always_comb begin
      reg_sel  = (dir_i == DIR_UP) ? step_i : LAST_STEP - step_i;
      addr_o   = (reg_sel == 2'd0) ? MIXER_PD : (reg_sel == 2'd1) ? MIXER_OTA : MIXER_BUFF;
      settle_o = (reg_sel == 2'd0) ? CNT_W'(T_PD) : (reg_sel == 2'd1) ? CNT_W'(T_OTA) : CNT_W'(T_BUFF);
      val_o    = (dir_i == DIR_UP) ? ((reg_sel == 2'd0) ? 2'd0 : (reg_sel == 2'd1) ? 2'd1 : buff_i)
                                   : ((reg_sel == 2'd0) ? 2'd1 : 2'd0);
   end
endmodule

// File: rtl/mixer_seq.sv
// mixer_seq: sequences PD/OTA/BUFF mixer writes with settle delays for power-up/down
module mixer_seq
   import mixer_seq_pkg::*;
#(
   parameter int T_PD    = 100,
   parameter int T_OTA   = 50,
   parameter int T_BUFF  = 10,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    up_req_i,
   input  logic                    down_req_i,
   input  logic [1:0]              buff_cfg_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic                    powered_o,
   output logic                    m_valid_o,
   output logic [MIXER_ADDR_W-1:0] m_address_o,
   output logic [DATA_W-1:0]       m_wdata_o,
   output logic                    m_wstrb_o,
   input  logic                    m_ready_i
);
   mseq_state_e             state_q, state_d;
   mseq_dir_e               dir_q, dir_d;
   logic [1:0]              step_q, step_d, buff_q, buff_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    abort_q, abort_d, err_q, err_d, powered_q, powered_d;
   logic [MIXER_ADDR_W-1:0] rom_addr;
   logic [1:0]              rom_val;
   logic [CNT_W-1:0]        rom_settle;
   logic                    abort_now, advance;

   mixer_seq_step_rom #(
      .T_PD    (T_PD),
      .T_OTA   (T_OTA),
      .T_BUFF  (T_BUFF),
      .CNT_W   (CNT_W)
   ) u_rom (
      .dir_i    (dir_q),
      .step_i   (step_q),
      .buff_i   (buff_q),
      .addr_o   (rom_addr),
      .val_o    (rom_val),
      .settle_o (rom_settle)
   );

   // state and datapath registers; reset returns everything to idle immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= MSEQ_IDLE;
         dir_q     <= DIR_UP;
         step_q    <= '0;
         buff_q    <= '0;
         cnt_q     <= '0;
         abort_q   <= 1'b0;
         err_q     <= 1'b0;
         powered_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         step_q    <= step_d;
         buff_q    <= buff_d;
         cnt_q     <= cnt_d;
         abort_q   <= abort_d;
         err_q     <= err_d;
         powered_q <= powered_d;
      end
   end

   // next state: cnt counts WR cycles for the timeout, then settle cycles after REL
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      step_d    = step_q;
      buff_d    = buff_q;
      cnt_d     = cnt_q;
      abort_d   = abort_q;
      err_d     = err_q;
      powered_d = powered_q;
      abort_now = (state_q == MSEQ_REL || state_q == MSEQ_SETTLE) && dir_q == DIR_UP && (abort_q || down_req_i);
      advance   = (state_q == MSEQ_REL && rom_settle == '0) || (state_q == MSEQ_SETTLE && cnt_q == CNT_W'(1));
      if (state_q == MSEQ_IDLE && (up_req_i || down_req_i)) begin
         state_d = MSEQ_WR;
         dir_d   = down_req_i ? DIR_DOWN : DIR_UP;
         step_d  = '0;
         cnt_d   = '0;
         err_d   = 1'b0;
         abort_d = 1'b0;
         buff_d  = down_req_i ? buff_q : buff_cfg_i;
      end else if (state_q == MSEQ_WR) begin
         abort_d = abort_q || (dir_q == DIR_UP && down_req_i);
         if (m_ready_i) begin
            state_d = MSEQ_REL;
         end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_d   = MSEQ_IDLE;
            err_d     = 1'b1;
            powered_d = 1'b0;
            abort_d   = 1'b0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (abort_now) begin
         state_d = MSEQ_WR;
         dir_d   = DIR_DOWN;
         step_d  = '0;
         cnt_d   = '0;
         abort_d = 1'b0;
      end else if (advance) begin
         if (step_q == LAST_STEP) begin
            state_d   = MSEQ_FIN;
            powered_d = (dir_q == DIR_UP);
         end else begin
            state_d = MSEQ_WR;
            step_d  = step_q + 2'd1;
            cnt_d   = '0;
         end
      end else if (state_q == MSEQ_REL) begin
         state_d = MSEQ_SETTLE;
         cnt_d   = rom_settle;
      end else if (state_q == MSEQ_SETTLE) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else if (state_q == MSEQ_FIN) begin
         state_d = MSEQ_IDLE;
      end
   end

   // outputs decoded from state; bus fields are zero whenever no write is offered
   always_comb begin
      m_valid_o   = (state_q == MSEQ_WR);
      m_wstrb_o   = m_valid_o;
      m_address_o = m_valid_o ? rom_addr : '0;
      m_wdata_o   = m_valid_o ? {{(DATA_W-2){1'b0}}, rom_val} : '0;
      busy_o      = (state_q == MSEQ_WR || state_q == MSEQ_REL || state_q == MSEQ_SETTLE);
      done_o      = (state_q == MSEQ_FIN);
      err_o       = err_q;
      powered_o   = powered_q;
   end
endmodule
